// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing defaults, axis state encoding and total-count helper
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CNT_LIMIT    = 1024;
  typedef enum logic [1:0] {ACT, FP, SYNC, BP} axis_state_e;
  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: timing enable and decoded sync/blank/coordinate bundle
interface vga_timing_if;
  logic       en;
  logic [9:0] x;
  logic [9:0] y;
  logic       de;
  logic       hs;
  logic       vs;
  logic       line_start;
  logic       frame_start;
  logic       hs_d;
  logic       vs_d;
  logic       de_d;
  modport master (input en, output x, y, de, hs, vs, line_start, frame_start, hs_d, vs_d, de_d);
  modport slave  (output en, input x, y, de, hs, vs, line_start, frame_start, hs_d, vs_d, de_d);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis, counting ACT->FP->SYNC->BP and wrapping at the total
module vga_axis_counter
  import vga_pkg::axis_state_e;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [9:0]  count,
  output axis_state_e state,
  output logic        wrap
);
  localparam int TOTAL = vga_pkg::axis_total(ACTIVE, FP, SYNC, BP);
  logic [9:0]  count_nx;
  axis_state_e state_nx;
  always_comb begin
    wrap     = count == 10'(TOTAL - 1);
    count_nx = wrap ? '0 : count + 10'd1;
    case (state)
      vga_pkg::ACT:  state_nx = count == 10'(ACTIVE - 1) ? vga_pkg::FP : state;
      vga_pkg::FP:   state_nx = count == 10'(ACTIVE + FP - 1) ? vga_pkg::SYNC : state;
      vga_pkg::SYNC: state_nx = count == 10'(ACTIVE + FP + SYNC - 1) ? vga_pkg::BP : state;
      default:       state_nx = wrap ? vga_pkg::ACT : state;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      state <= vga_pkg::ACT;
    end else if (step) begin
      count <= count_nx;
      state <= state_nx;
    end
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA h/v timing with registered decode and a pipeline-matched sync/blank delay line
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 2
) (
  input logic          clk,
  input logic          rst,
  vga_timing_if.master vif
);
  if (axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP) > CNT_LIMIT ||
      axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP) > CNT_LIMIT) begin : g_bad_total
    $error("vga_timing_ctrl: timing total exceeds 10-bit counter range");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_bad_delay
    $error("vga_timing_ctrl: PIPE_DELAY must be 0..8");
  end
  logic [9:0]  hc, vc;
  axis_state_e hst, vst;
  logic        h_wrap, unused_v_wrap;
  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk(clk), .rst(rst), .step(vif.en), .count(hc), .state(hst), .wrap(h_wrap)
  );
  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk(clk), .rst(rst), .step(vif.en & h_wrap), .count(vc), .state(vst), .wrap(unused_v_wrap)
  );
  // Outputs are a registered decode of the counters, so they trail them by one enabled clock.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vif.x           <= '0;
      vif.y           <= '0;
      vif.de          <= 1'b0;
      vif.hs          <= !HS_POL;
      vif.vs          <= !VS_POL;
      vif.line_start  <= 1'b0;
      vif.frame_start <= 1'b0;
    end else begin
      vif.line_start  <= vif.en && hc == '0;
      vif.frame_start <= vif.en && hc == '0 && vc == '0;
      if (vif.en) begin
        vif.x  <= hc;
        vif.y  <= vc;
        vif.de <= hst == ACT && vst == ACT;
        vif.hs <= hst == SYNC ? HS_POL : !HS_POL;
        vif.vs <= vst == SYNC ? VS_POL : !VS_POL;
      end
    end
  if (PIPE_DELAY == 0) begin : g_nodelay
    assign {vif.hs_d, vif.vs_d, vif.de_d} = {vif.hs, vif.vs, vif.de};
  end else begin : g_delay
    logic [2:0] dl [PIPE_DELAY];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        for (int i = 0; i < PIPE_DELAY; i++) dl[i] <= {!HS_POL, !VS_POL, 1'b0};
      end else if (vif.en) begin
        dl[0] <= {vif.hs, vif.vs, vif.de};
        for (int i = PIPE_DELAY - 1; i > 0; i--) dl[i] <= dl[i-1];
      end
    assign {vif.hs_d, vif.vs_d, vif.de_d} = dl[PIPE_DELAY-1];
  end
endmodule
